// File: rtl/template_readback_chain_if.sv
// template_readback_chain_if: parallel capture side and serial valid/ready readback side of the template chain
interface template_readback_chain_if #(parameter int WIDTH = 8);
    logic             CAPTURE_REQ;
    logic             ABORT;
    logic [WIDTH-1:0] SAMPLE;
    logic             SDO_READY;
    logic             SDO;
    logic             SDO_VALID;
    logic             BUSY;
    logic             DONE;
    modport master (
        output CAPTURE_REQ, ABORT, SAMPLE, SDO_READY,
        input  SDO, SDO_VALID, BUSY, DONE
    );
    modport slave (
        input  CAPTURE_REQ, ABORT, SAMPLE, SDO_READY,
        output SDO, SDO_VALID, BUSY, DONE
    );
endinterface

// File: rtl/template_readback_chain.sv
// template_readback_chain: snapshot SAMPLE, shift it out LSB first under valid/ready; READBACK_PARITY_EN appends even parity
module template_readback_chain #(
    parameter int WIDTH = 8
) (
    input logic CLK,
    input logic RST,
    template_readback_chain_if.slave bus
);
`ifdef READBACK_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
    state_t           state, state_n;
    logic [FRAME-1:0] shadow, shadow_n, cap_word;
    logic [CW-1:0]    cnt, cnt_n;
    logic             last;
    logic             sdo, sdo_valid, busy, done;
`ifdef READBACK_PARITY_EN
    assign cap_word = {^bus.SAMPLE, bus.SAMPLE};
`else
    assign cap_word = bus.SAMPLE;
`endif
    assign last = cnt == CW'(FRAME - 1);
    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        cnt_n    = cnt;
        case (state)
            IDLE: if (bus.CAPTURE_REQ) begin
                state_n  = SHIFT;
                shadow_n = cap_word;
                cnt_n    = '0;
            end
            SHIFT: if (bus.ABORT) state_n = IDLE;
            else if (bus.SDO_READY) begin
                shadow_n = shadow >> 1;
                cnt_n    = cnt + 1'b1;
                state_n  = last ? FINISH : SHIFT;
            end
            default: state_n = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            shadow    <= '0;
            cnt       <= '0;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            shadow    <= shadow_n;
            cnt       <= cnt_n;
            sdo       <= state_n == SHIFT && shadow_n[0];
            sdo_valid <= state_n == SHIFT;
            busy      <= state_n != IDLE;
            done      <= state_n == FINISH;
        end
    end
    assign bus.SDO       = sdo;
    assign bus.SDO_VALID = sdo_valid;
    assign bus.BUSY      = busy;
    assign bus.DONE      = done;
endmodule

// File: tb/tb_template_readback_chain.sv
// tb_template_readback_chain: directed frames checked by a queue scoreboard popped on accepted bits and DONE
module tb_template_readback_chain;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;
    template_readback_chain_if #(.WIDTH(8)) bus();
    template_readback_chain #(.WIDTH(8)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
`ifdef READBACK_PARITY_EN
    localparam int FR = 9;
`else
    localparam int FR = 8;
`endif
    int total = 0, bad = 0, cyc = 0, done_cnt = 0, done_cyc = 0, cap_cyc = 0, done0 = 0;
    int q[$];
    always @(posedge CLK) cyc <= cyc + 1;
    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", n, act, exp, cyc);
        end
    endtask
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask
    // bit 8 of v is the hand-computed even parity, used only when parity is built in
    task automatic push_frame(input logic [8:0] v, input int n, input bit fin);
        for (int i = 0; i < n; i++) q.push_back(int'(v[i]));
        if (fin) q.push_back(2);
    endtask
    task automatic outs_zero(input string n);
        chk(n, int'({bus.SDO, bus.SDO_VALID, bus.BUSY, bus.DONE}), 0);
    endtask
    task automatic capture(input logic [7:0] s);
        done0 = done_cnt;
        bus.SAMPLE = s;
        bus.CAPTURE_REQ = 1'b1;
        tick;
        bus.CAPTURE_REQ = 1'b0;
        cap_cyc = cyc;
    endtask
    task automatic wait_done(input int lat, input string n);
        for (int i = 0; i < 60 && done_cnt == done0; i++) tick;
        if (done_cnt == done0) chk({n, "_timeout"}, 0, 1);
        else begin
            chk({n, "_latency"}, done_cyc - cap_cyc, lat);
            chk({n, "_idle_after"}, int'({bus.BUSY, bus.DONE, bus.SDO_VALID}), 0);
        end
    endtask
    always @(negedge CLK) begin
        if (!bus.SDO_VALID) chk("sdo_zero_when_invalid", int'(bus.SDO), 0);
        if (bus.SDO_VALID && bus.SDO_READY && !bus.ABORT && !RST) begin
            if (q.size() == 0) chk("unexpected_bit", 1, 0);
            else chk("bit", int'(bus.SDO), q.pop_front());
        end else if (bus.SDO_VALID && q.size() != 0) chk("stall_hold", int'(bus.SDO), q[0]);
        if (bus.DONE) begin
            done_cnt++;
            done_cyc = cyc;
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_order", 2, q.pop_front());
        end
    end
    initial begin
        bus.CAPTURE_REQ = 1'b0;
        bus.ABORT = 1'b0;
        bus.SAMPLE = '0;
        bus.SDO_READY = 1'b0;
        repeat (3) tick;
        RST = 1'b0;
        repeat (5) begin
            tick;
            outs_zero("reset_idle");
        end
        bus.SDO_READY = 1'b1;
        push_frame(9'h0A5, FR, 1'b1);
        capture(8'hA5);
        chk("first_bit_latency", int'({bus.BUSY, bus.SDO_VALID, bus.SDO}), 7);
        wait_done(FR, "a5");
        push_frame(9'h0A5, FR, 1'b1);
        capture(8'hA5);
        tick;
        tick;
        bus.SDO_READY = 1'b0;
        repeat (3) tick;
        chk("stall_sdo", int'(bus.SDO), 1);
        bus.SDO_READY = 1'b1;
        wait_done(FR + 3, "a5_stall");
        push_frame(9'h101, FR, 1'b1);
        capture(8'h01);
        tick;
        bus.SAMPLE = 8'hFF;
        bus.CAPTURE_REQ = 1'b1;
        tick;
        bus.CAPTURE_REQ = 1'b0;
        wait_done(FR, "midframe_req");
        push_frame(9'h0A5, 4, 1'b0);
        capture(8'hA5);
        repeat (4) tick;
        bus.ABORT = 1'b1;
        tick;
        bus.ABORT = 1'b0;
        chk("abort_idle", int'({bus.SDO_VALID, bus.BUSY, bus.DONE}), 0);
        push_frame(9'h03C, FR, 1'b1);
        bus.ABORT = 1'b1;
        capture(8'h3C);
        bus.ABORT = 1'b0;
        wait_done(FR, "3c_after_abort");
        push_frame(9'h0A5, 6, 1'b0);
        capture(8'hA5);
        repeat (6) tick;
        RST = 1'b1;
        bus.SDO_READY = 1'b0;
        tick;
        outs_zero("rst_midframe");
        RST = 1'b0;
        bus.SDO_READY = 1'b1;
        repeat (3) begin
            tick;
            outs_zero("rst_after");
        end
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
